// File: rtl/lcd_bus_arbiter_if.sv
// Bundle between the two LCD requesters, the arbiter and the LCD pins.
// master = arbiter side, slave = requester/LCD side.
interface lcd_bus_arbiter_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       lock0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       lock1;
  logic       ack1;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_enable;
  logic [7:0] lcd_data;
  logic       busy;
  logic       grant_id;

  modport master (
    input  req0, rs0, data0, lock0,
    input  req1, rs1, data1, lock1,
    output ack0, ack1,
    output lcd_rs, lcd_rw, lcd_enable, lcd_data,
    output busy, grant_id
  );

  modport slave (
    output req0, rs0, data0, lock0,
    output req1, rs1, data1, lock1,
    input  ack0, ack1,
    input  lcd_rs, lcd_rw, lcd_enable, lcd_data,
    input  busy, grant_id
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester HD44780 bus arbiter with enable strobe timing.
// Optional owner locking between bytes: define ARB_LOCK_EN.
module lcd_bus_arbiter #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 4,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 10,
  parameter int LONG_WAIT_CYC = 50
) (
  input logic               clk,
  input logic               reset,
  lcd_bus_arbiter_if.master bus
);
  localparam int M0 = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int M1 = (M0 > HOLD_CYC) ? M0 : HOLD_CYC;
  localparam int M2 = (M1 > CMD_WAIT_CYC) ? M1 : CMD_WAIT_CYC;
  localparam int MX = (M2 > LONG_WAIT_CYC) ? M2 : LONG_WAIT_CYC;
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, WAIT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rs_q, rs_n;
  logic [7:0]    data_q, data_n;
  logic          gid_q, gid_n;
  logic          last_q, last_n;
  logic          ack0_q, ack0_n;
  logic          ack1_q, ack1_n;
  logic          own_v, own_v_n;
  logic          own_id, own_id_n;
  logic          keep;
  logic          lock_w;
  logic          elig0, elig1;
  logic          win1;
  logic          long_cmd;

`ifdef ARB_LOCK_EN
  assign keep   = own_v & (own_id ? bus.lock1 : bus.lock0);
  assign lock_w = win1 ? bus.lock1 : bus.lock0;
`else
  logic unused_lock;
  assign unused_lock = bus.lock0 ^ bus.lock1 ^ own_v ^ own_id;
  assign keep        = 1'b0;
  assign lock_w      = 1'b0;
`endif

  // A held lock shuts out the non-owner even when the owner is silent
  assign elig0 = bus.req0 & ~(keep & own_id);
  assign elig1 = bus.req1 & ~(keep & ~own_id);
  assign win1  = elig1 & (~elig0 | ~last_q);

  assign long_cmd = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rs_n     = rs_q;
    data_n   = data_q;
    gid_n    = gid_q;
    last_n   = last_q;
    ack0_n   = 1'b0;
    ack1_n   = 1'b0;
    own_v_n  = own_v;
    own_id_n = own_id;
    unique case (state)
      IDLE: begin
        own_v_n = keep;
        if (elig0 | elig1) begin
          state_n  = SETUP;
          cnt_n    = CW'(SETUP_CYC - 1);
          rs_n     = win1 ? bus.rs1 : bus.rs0;
          data_n   = win1 ? bus.data1 : bus.data0;
          gid_n    = win1;
          last_n   = win1;
          ack0_n   = ~win1;
          ack1_n   = win1;
          own_v_n  = lock_w;
          own_id_n = win1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = CW'(EN_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = WAIT;
          cnt_n   = long_cmd ? CW'(LONG_WAIT_CYC - 1)
                             : CW'(CMD_WAIT_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      gid_q  <= 1'b0;
      last_q <= 1'b1;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      own_v  <= 1'b0;
      own_id <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rs_q   <= rs_n;
      data_q <= data_n;
      gid_q  <= gid_n;
      last_q <= last_n;
      ack0_q <= ack0_n;
      ack1_q <= ack1_n;
      own_v  <= own_v_n;
      own_id <= own_id_n;
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_enable = (state == PULSE);
  assign bus.lcd_data   = data_q;
  assign bus.busy       = (state != IDLE);
  assign bus.grant_id   = gid_q;
endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single 8-bit HD44780-style LCD bus between two requesters, e.g. requester 0 = init/config sequencer and requester 1 = CGRAM/figure writer.
- Serialises byte writes, generates the enable strobe with programmable setup, pulse, hold and post-command wait, and stretches the wait for slow commands (clear, home).
- Sits between the display-content controllers and the LCD pins.

Parameters:
- SETUP_CYC, 2: cycles rs/data are stable with enable low before the pulse (min 1).
- EN_CYC, 4: cycles enable is high (min 1).
- HOLD_CYC, 2: cycles data is held with enable low after the pulse (min 1).
- CMD_WAIT_CYC, 10: idle cycles after a normal write (min 1).
- LONG_WAIT_CYC, 50: idle cycles after a long command, i.e. rs=0 and data 8'h01 or 8'h02 (min 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 has a byte pending
- rs0  in  1  requester 0 register select (0 = command, 1 = data)
- data0  in  8  requester 0 byte
- lock0  in  1  requester 0 keeps bus ownership between bytes
- ack0  out  1  one-cycle pulse: requester 0 byte accepted
- req1, rs1, data1, lock1, ack1: same meaning for requester 1
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; constant 0 (write only)
- lcd_enable  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus
- busy  out  1  high in every state except IDLE
- grant_id  out  1  requester owning the current or last transfer

Behaviour:
Reset (synchronous):
- At the first clk edge with reset=1: state IDLE, lcd_rs=0, lcd_enable=0, lcd_data=0, ack0=ack1=0, busy=0, grant_id=0, last_grant=1 (so requester 0 wins the first tie), lock ownership cleared.
- Reset mid-transfer aborts immediately. lcd_enable drops at that edge and no ack is re-issued.

States: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE. One down-counter is reloaded on each state entry; width is $clog2(max parameter + 1).

IDLE:
- At an edge where at least one eligible req is sampled high: select the winner, latch lcd_rs/lcd_data from its rs/data, set grant_id, register ack of the winner high for exactly the next cycle, go to SETUP.
- With no eligible req: stay in IDLE; outputs hold their last values, enable stays 0.

Arbitration:
- Only one req high: it wins.
- Both high: the requester != last_grant wins (round robin). last_grant updates on each grant.
- Locked owner (see Optional Feature): only the owner is eligible. If the owner's req is low, the bus idles and the other requester is not served.

Transfer timing, counting from the edge leaving IDLE:
- SETUP: SETUP_CYC cycles, enable=0.
- PULSE: EN_CYC cycles, enable=1.
- HOLD: HOLD_CYC cycles, enable=0, data unchanged.
- WAIT: CMD_WAIT_CYC cycles, or LONG_WAIT_CYC if the latched rs=0 and data is 8'h01 or 8'h02.
- Total busy time = SETUP_CYC + EN_CYC + HOLD_CYC + wait cycles.
- lcd_rs and lcd_data are stable from SETUP through WAIT.

Handshake:
- Requester holds req/rs/data stable until ack is sampled high.
- At that same edge it drops req or presents the next byte.
- The arbiter never samples req outside IDLE, so a byte presented during a transfer waits for it to finish.
- Both acks are never high together.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined: lockN sampled with the grant in IDLE makes N the owner. The owner stays owner at every return to IDLE while its lock is high. Ownership is released at the first IDLE evaluation where the owner's lock is low; normal round robin then applies in that same evaluation. This keeps 8-byte CGRAM character writes uninterrupted.
- Not defined: lock0/lock1 are ignored (may be left unconnected) and pure round robin always applies.

Test Plan:
1. Default params, req0=1, rs0=0, data0=8'h38 -> ack0 one cycle after the sampling edge; lcd_data=8'h38, lcd_rs=0; enable high exactly 4 cycles starting 2 cycles after leaving IDLE; busy high for 2+4+2+10=18 cycles; then idle.
2. req0 with rs0=0, data0=8'h01 -> WAIT lasts 50 cycles, busy 58 cycles. Then rs0=1, data0=8'h01 -> WAIT 10, busy 18.
3. req0 and req1 held high continuously from reset, data0=8'hAA, data1=8'h55 -> grants alternate 0,1,0,1; lcd_data sequence AA,55,AA,55; acks never overlap.
4. ARB_LOCK_EN defined: lock1=1 and req1 high for 8 bytes 8'h40, 8'h1F… while req0 also high -> all 8 requester-1 bytes sent back to back, and no ack0 until lock1 drops. Without ARB_LOCK_EN -> grants alternate.
5. Assert reset during PULSE -> at the next edge lcd_enable=0, lcd_data=0, busy=0, state IDLE. After release with req1 high, requester 1 is granted normally.
6. Params SETUP_CYC=EN_CYC=HOLD_CYC=CMD_WAIT_CYC=1 -> busy exactly 4 cycles per byte; enable high exactly 1 cycle.
